// File: rtl/energy_lut_port_arb.sv
// Port A arbiter for the energy-cal coefficient BRAM: photon reads vs. loader writes.
// Optional ENERGY_LUT_DROP_CNT_EN builds the saturating photon drop counter.
module energy_lut_port_arb #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int TAG_W      = 16,
  parameter int RD_LATENCY = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STARVE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ph_valid,
  input  logic [ADDR_W-1:0] ph_addr,
  input  logic [TAG_W-1:0]  ph_tag,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_data,
  output logic              bram_en_a,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wr_data,
  input  logic [DATA_W-1:0] bram_rd_data,
  output logic              coef_valid,
  output logic [DATA_W-1:0] coef_data,
  output logic [TAG_W-1:0]  coef_tag,
  output logic              fifo_full,
  output logic [15:0]       ph_drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SB = $clog2(MAX_STARVE + 1);
  localparam int SW = (SB > 4) ? SB : 4;
  localparam logic [SW:0] STARVE_LIM = (SW+1)'(MAX_STARVE);

  logic [ADDR_W-1:0]     fifo_addr [FIFO_DEPTH];
  logic [TAG_W-1:0]      fifo_tag  [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [PW:0]           count_nxt;
  logic                  full_q;
  logic                  empty;
  logic [SW-1:0]         starve_cnt;
  logic                  forced;
  logic                  rd_gnt;
  logic                  wr_gnt;
  logic                  push;
  logic                  pop;
  logic [ADDR_W-1:0]     addr_hold;
  logic [DATA_W-1:0]     data_hold;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [TAG_W-1:0]      tag_pipe [RD_LATENCY];

  assign empty  = (count == '0);
  // starve_cnt + 1 > MAX_STARVE, written so MAX_STARVE = 0 stays well formed
  assign forced = upd_valid &&
                  (({1'b0, starve_cnt} + (SW+1)'(1)) > STARVE_LIM);

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (rst_n) begin
      if (forced)         wr_gnt = 1'b1;
      else if (!empty)    rd_gnt = 1'b1;
      else if (upd_valid) wr_gnt = 1'b1;
    end
  end

  assign pop  = rd_gnt;
  assign push = ph_valid && (!full_q || pop);

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + (PW+1)'(1);
      2'b01:   count_nxt = count - (PW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  assign upd_ready    = wr_gnt;
  assign bram_en_a    = wr_gnt | rd_gnt;
  assign bram_we      = wr_gnt;
  assign bram_addr    = wr_gnt ? upd_addr :
                        rd_gnt ? fifo_addr[rd_ptr] : addr_hold;
  assign bram_wr_data = wr_gnt ? upd_data : data_hold;
  assign fifo_full    = full_q;
  assign coef_valid   = vld_pipe[RD_LATENCY-1];
  assign coef_data    = coef_valid ? bram_rd_data : '0;
  assign coef_tag     = coef_valid ? tag_pipe[RD_LATENCY-1] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      starve_cnt <= '0;
      addr_hold  <= '0;
      data_hold  <= '0;
      vld_pipe   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count  <= count_nxt;
      full_q <= (count_nxt == (PW+1)'(FIFO_DEPTH));
      if (upd_valid && !wr_gnt) begin
        if (starve_cnt != '1) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
      if (bram_en_a) addr_hold <= bram_addr;
      if (wr_gnt)    data_hold <= upd_data;
      for (int i = RD_LATENCY - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
      vld_pipe[0] <= rd_gnt;
    end
  end

  // payload storage needs no reset; validity lives in count and vld_pipe
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ph_addr;
      fifo_tag[wr_ptr]  <= ph_tag;
    end
    for (int i = RD_LATENCY - 1; i > 0; i--) tag_pipe[i] <= tag_pipe[i-1];
    tag_pipe[0] <= fifo_tag[rd_ptr];
  end

`ifdef ENERGY_LUT_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt;

  assign drop = ph_valid && full_q && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign ph_drop_cnt = drop_cnt;
`else
  assign ph_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_energy_lut_port_arb.sv
// Bench for energy_lut_port_arb: BRAM model, result scoreboard, drop saturation.
// A second instance with MAX_STARVE=0 never reads, so every full-FIFO photon drops.
module tb_energy_lut_port_arb;

  typedef struct packed {
    logic [15:0] tag;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        ph_valid;
  logic [9:0]  ph_addr;
  logic [15:0] ph_tag;
  logic        upd_valid;
  logic        upd_ready;
  logic [9:0]  upd_addr;
  logic [63:0] upd_data;
  logic        bram_en_a;
  logic        bram_we;
  logic [9:0]  bram_addr;
  logic [63:0] bram_wr_data;
  logic [63:0] bram_rd_data;
  logic        coef_valid;
  logic [63:0] coef_data;
  logic [15:0] coef_tag;
  logic        fifo_full;
  logic [15:0] ph_drop_cnt;

  logic        s_ph_valid;
  logic        s_upd_valid;
  logic        s_upd_ready;
  logic        s_en;
  logic        s_we;
  logic [9:0]  s_addr;
  logic [63:0] s_wr_data;
  logic        s_coef_valid;
  logic [63:0] s_coef_data;
  logic [15:0] s_coef_tag;
  logic        s_fifo_full;
  logic [15:0] s_drop_cnt;

  int   total;
  int   bad;
  exp_t exp_q[$];

  logic [63:0] mem [1024];
  bit          wr_seen [1024];
  logic [63:0] rd_s0;
  logic [63:0] rd_s1;
  logic [63:0] rd_s2;

  energy_lut_port_arb dut (
    .clk(clk), .rst_n(rst_n),
    .ph_valid(ph_valid), .ph_addr(ph_addr), .ph_tag(ph_tag),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_addr(upd_addr), .upd_data(upd_data),
    .bram_en_a(bram_en_a), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wr_data(bram_wr_data),
    .bram_rd_data(bram_rd_data),
    .coef_valid(coef_valid), .coef_data(coef_data), .coef_tag(coef_tag),
    .fifo_full(fifo_full), .ph_drop_cnt(ph_drop_cnt)
  );

  energy_lut_port_arb #(.MAX_STARVE(0)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .ph_valid(s_ph_valid), .ph_addr(10'h011), .ph_tag(16'h0011),
    .upd_valid(s_upd_valid), .upd_ready(s_upd_ready),
    .upd_addr(10'h022), .upd_data(64'h22),
    .bram_en_a(s_en), .bram_we(s_we),
    .bram_addr(s_addr), .bram_wr_data(s_wr_data),
    .bram_rd_data(64'h0),
    .coef_valid(s_coef_valid), .coef_data(s_coef_data), .coef_tag(s_coef_tag),
    .fifo_full(s_fifo_full), .ph_drop_cnt(s_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] coef_f(input logic [9:0] a);
    return {16'hC0EF, 6'h00, a, 16'hA5A5, 6'h3F, a};
  endfunction

  // 3-cycle port A model; unwritten words read back coef_f(addr)
  always @(posedge clk) begin
    if (bram_en_a) begin
      if (bram_we) begin
        mem[bram_addr]     <= bram_wr_data;
        wr_seen[bram_addr] <= 1'b1;
      end else begin
        rd_s0 <= wr_seen[bram_addr] ? mem[bram_addr] : coef_f(bram_addr);
      end
    end
    rd_s1 <= rd_s0;
    rd_s2 <= rd_s1;
  end
  assign bram_rd_data = rd_s2;

  always @(negedge clk) begin
    if (coef_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL coef_unexpected tag=%h data=%h want=none",
                 coef_tag, coef_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({coef_tag, coef_data} !== {e.tag, e.data}) begin
          bad++;
          $display("FAIL coef_result got=%h/%h want=%h/%h",
                   coef_tag, coef_data, e.tag, e.data);
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ph_valid  = 1'b0;
    ph_addr   = '0;
    ph_tag    = '0;
    upd_valid = 1'b0;
    upd_addr  = '0;
    upd_data  = '0;
  endtask

  task automatic push_exp(input logic [15:0] t, input logic [63:0] d);
    exp_q.push_back({t, d});
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) next_cycle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain left=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
    next_cycle();
  endtask

  task automatic test_reset;
    logic [200:0] obs;
    #3;
    obs = {upd_ready, bram_en_a, bram_we, bram_addr, bram_wr_data,
           coef_valid, coef_data, coef_tag, fifo_full, ph_drop_cnt};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_photon;
    ph_valid = 1'b1;
    ph_addr  = 10'h12A;
    ph_tag   = 16'hBEEF;
    push_exp(16'hBEEF, coef_f(10'h12A));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++;
        if (bram_en_a !== 1'b0) begin
          bad++;
          $display("FAIL single_c0_en got=%b want=0", bram_en_a);
        end
      end
      if (k == 1) begin
        total++;
        if ({bram_en_a, bram_we, bram_addr} !== {1'b1, 1'b0, 10'h12A}) begin
          bad++;
          $display("FAIL single_issue got=%b%b%h want=1012a",
                   bram_en_a, bram_we, bram_addr);
        end
      end
      if (k == 3 || k == 4) begin
        total++;
        if (coef_valid !== (k == 4)) begin
          bad++;
          $display("FAIL single_latency c%0d got=%b want=%b",
                   k, coef_valid, (k == 4));
        end
      end
      next_cycle();
      ph_valid = 1'b0;
    end
    wait_drain("single");
  endtask

  task automatic test_update_idle;
    upd_valid = 1'b1;
    upd_addr  = 10'h3FF;
    upd_data  = 64'h0123456789ABCDEF;
    @(negedge clk);
    total++;
    if ({upd_ready, bram_en_a, bram_we, bram_addr, bram_wr_data} !==
        {3'b111, 10'h3FF, 64'h0123456789ABCDEF}) begin
      bad++;
      $display("FAIL upd_write got=%b%b%b %h %h want=111 3ff 0123456789abcdef",
               upd_ready, bram_en_a, bram_we, bram_addr, bram_wr_data);
    end
    next_cycle();
    upd_valid = 1'b0;
    ph_valid  = 1'b1;
    ph_addr   = 10'h3FF;
    ph_tag    = 16'h0077;
    push_exp(16'h0077, 64'h0123456789ABCDEF);
    @(negedge clk);
    total++;
    if ({bram_en_a, bram_we, bram_addr, bram_wr_data} !==
        {2'b00, 10'h3FF, 64'h0123456789ABCDEF}) begin
      bad++;
      $display("FAIL idle_hold got=%b%b %h %h want=00 3ff 0123456789abcdef",
               bram_en_a, bram_we, bram_addr, bram_wr_data);
    end
    next_cycle();
    ph_valid = 1'b0;
    wait_drain("update");
  endtask

  task automatic test_starvation;
    int   upd_idx;
    logic exp_we;
    logic exp_en;
    upd_idx = 0;
    for (int i = 0; i < 20; i++) begin
      ph_valid  = 1'b1;
      ph_addr   = 10'h040 + 10'(i);
      ph_tag    = 16'h1000 + 16'(i);
      push_exp(ph_tag, coef_f(ph_addr));
      upd_valid = (i > 0);
      upd_addr  = 10'h200 + 10'(upd_idx);
      upd_data  = 64'hD000 + 64'(upd_idx);
      @(negedge clk);
      exp_we = (i == 9 || i == 18);
      exp_en = (i > 0);
      total++;
      if ({bram_en_a, bram_we, upd_ready, fifo_full} !==
          {exp_en, exp_we, exp_we, 1'b0}) begin
        bad++;
        $display("FAIL starve_c%0d en/we/rdy/full got=%b%b%b%b want=%b%b%b0",
                 i, bram_en_a, bram_we, upd_ready, fifo_full,
                 exp_en, exp_we, exp_we);
      end
      if (upd_ready) upd_idx++;
      next_cycle();
    end
    idle_inputs();
    wait_drain("starve");
    total++;
    if (ph_drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL starve_no_drop got=%0d want=0", ph_drop_cnt);
    end
  endtask

  task automatic test_overflow;
    int          upd_idx;
    logic        exp_we;
    logic        exp_full;
    logic [15:0] exp_drops;
    upd_idx = 0;
    for (int i = 0; i < 47; i++) begin
      ph_valid  = 1'b1;
      ph_addr   = 10'h080 + 10'(i);
      ph_tag    = 16'h2000 + 16'(i);
      if (!(i == 36 || i == 45)) push_exp(ph_tag, coef_f(ph_addr));
      upd_valid = 1'b1;
      upd_addr  = 10'h240 + 10'(upd_idx);
      upd_data  = 64'hE000 + 64'(upd_idx);
      @(negedge clk);
      exp_we   = (i % 9 == 0);
      exp_full = (i >= 28);
      total++;
      if ({bram_en_a, bram_we, fifo_full} !== {1'b1, exp_we, exp_full}) begin
        bad++;
        $display("FAIL ovf_c%0d en/we/full got=%b%b%b want=1%b%b",
                 i, bram_en_a, bram_we, fifo_full, exp_we, exp_full);
      end
      if (upd_ready) upd_idx++;
      next_cycle();
    end
    idle_inputs();
    wait_drain("ovf");
`ifdef ENERGY_LUT_DROP_CNT_EN
    exp_drops = 16'd2;
`else
    exp_drops = 16'd0;
`endif
    total++;
    if (ph_drop_cnt !== exp_drops) begin
      bad++;
      $display("FAIL ovf_drop_cnt got=%0d want=%0d", ph_drop_cnt, exp_drops);
    end
  endtask

  task automatic test_reset_midflight;
    logic [200:0] obs;
    ph_valid = 1'b1;
    ph_addr  = 10'h050;
    ph_tag   = 16'h3000;
    push_exp(ph_tag, coef_f(ph_addr));
    next_cycle();
    ph_addr  = 10'h051;
    ph_tag   = 16'h3001;
    push_exp(ph_tag, coef_f(ph_addr));
    next_cycle();
    upd_valid = 1'b1;
    rst_n     = 1'b0;
    exp_q.delete();
    #1;
    obs = {upd_ready, bram_en_a, bram_we, bram_addr, bram_wr_data,
           coef_valid, coef_data, coef_tag, fifo_full, ph_drop_cnt};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h want=0", obs);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if ({bram_en_a, coef_valid, fifo_full, ph_drop_cnt} !== '0) begin
        bad++;
        $display("FAIL midreset_after c%0d en/cv/full/drops got=%b%b%b %0d want=000 0",
                 k, bram_en_a, coef_valid, fifo_full, ph_drop_cnt);
      end
      next_cycle();
    end
  endtask

  task automatic test_drop_saturation;
    logic [15:0] exp_mid;
    logic [15:0] exp_end;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    s_ph_valid  = 1'b1;
    s_upd_valid = 1'b1;
    repeat (65538) @(posedge clk);
    #1;
`ifdef ENERGY_LUT_DROP_CNT_EN
    exp_mid = 16'hFFFE;
    exp_end = 16'hFFFF;
`else
    exp_mid = 16'h0000;
    exp_end = 16'h0000;
`endif
    total++;
    if ({s_fifo_full, s_drop_cnt} !== {1'b1, exp_mid}) begin
      bad++;
      $display("FAIL sat_mid full/drops got=%b %h want=1 %h",
               s_fifo_full, s_drop_cnt, exp_mid);
    end
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (s_drop_cnt !== exp_end) begin
      bad++;
      $display("FAIL sat_end got=%h want=%h", s_drop_cnt, exp_end);
    end
    s_ph_valid  = 1'b0;
    s_upd_valid = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    s_ph_valid  = 1'b0;
    s_upd_valid = 1'b0;
    idle_inputs();
    ph_valid    = 1'b1;
    upd_valid   = 1'b1;
    test_reset();
    test_single_photon();
    test_update_idle();
    test_starvation();
    test_overflow();
    test_reset_midflight();
    test_drop_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/energy_lut_port_arb.md
Name: energy_lut_port_arb

Overview:
- Arbitrates port A of the 1024 x 64-bit energy-calibration coefficient BRAM in the capture/energy-cal datapath.
- Two requesters share the port:
  - photon lookup stream (read, resonator ID as address, tag carried through);
  - coefficient update stream from the software loader (write).
- Photon reads normally win. A starvation guard forces update writes through, and a small photon FIFO absorbs the displaced reads.

Parameters:
- ADDR_W, 10, BRAM port A address width (1024 entries).
- DATA_W, 64, coefficient word width.
- TAG_W, 16, photon tag width carried alongside each lookup.
- RD_LATENCY, 3, BRAM port A read latency in cycles (core and primitive output registers enabled).
- FIFO_DEPTH, 4, photon request FIFO depth; power of 2, >= 2.
- MAX_STARVE, 8, consecutive denied cycles before a pending update is forced.

Ports:
- clk  in  1  datapath clock.
- rst_n  in  1  asynchronous active-low reset.
- ph_valid  in  1  photon lookup request.
- ph_addr  in  ADDR_W  resonator ID / LUT address.
- ph_tag  in  TAG_W  tag returned with the coefficients.
- upd_valid  in  1  coefficient write pending.
- upd_ready  out  1  write issued this cycle (combinational).
- upd_addr  in  ADDR_W  write address.
- upd_data  in  DATA_W  write data.
- bram_en_a  out  1  port A enable.
- bram_we  out  1  port A write enable.
- bram_addr  out  ADDR_W  port A address.
- bram_wr_data  out  DATA_W  port A write data.
- bram_rd_data  in  DATA_W  port A read data.
- coef_valid  out  1  coefficient result valid.
- coef_data  out  DATA_W  coefficients for the tagged photon.
- coef_tag  out  TAG_W  tag of the returned photon.
- fifo_full  out  1  photon FIFO full.
- ph_drop_cnt  out  16  saturating count of dropped photons.

Behaviour:
- Reset values, asynchronous on rst_n low: all outputs 0. FIFO pointers, starvation counter, read-valid pipe and drop count clear. Releasing reset mid-operation discards any in-flight reads; no coef_valid is produced for them.
- Photon path has no backpressure.
  - ph_valid with FIFO not full: {addr, tag} pushed this cycle.
  - ph_valid with FIFO full: photon dropped and ph_drop_cnt increments, saturating at 0xFFFF.
  - Push and pop in the same cycle while full: the push is accepted (pop frees the slot first).
- Arbitration is evaluated each cycle from registered FIFO state. A photon pushed at cycle N is issuable at N+1 at the earliest. Grant priority, highest first:
  1. Forced write: upd_valid and starve_cnt >= MAX_STARVE.
  2. Read: FIFO not empty; pop head.
  3. Write: upd_valid.
  4. Idle.
- Outputs by grant:
  - Write: bram_en_a=1, bram_we=1, bram_addr=upd_addr, bram_wr_data=upd_data, upd_ready=1.
  - Read: bram_en_a=1, bram_we=0, bram_addr=head addr.
  - Idle: bram_en_a=0, bram_we=0. bram_addr and bram_wr_data hold their previous values.
- Port A outputs are combinational from registered state plus upd_*. upd_ready is combinational; a write occurs exactly when upd_valid && upd_ready.
- Starvation counter (4 bits minimum, wide enough for MAX_STARVE):
  - +1 each cycle upd_valid is high and not granted, saturating.
  - Cleared on a write grant or when upd_valid is low.
- Read return path: a RD_LATENCY-deep shift register of {valid, tag}.
  - A read issued at cycle T gives coef_valid=1 at T+RD_LATENCY, with coef_data=bram_rd_data and coef_tag=tag. coef_valid is otherwise 0.
  - Minimum photon-to-result latency is RD_LATENCY+1 = 4 cycles.
- Ordering: photon results return in arrival order. A read issued the cycle after a write to the same address returns the new data. No read and write to port A ever occur in the same cycle.
- fifo_full is registered and reflects occupancy == FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: ENERGY_LUT_DROP_CNT_EN.
- Defined: ph_drop_cnt is a 16-bit saturating counter as above.
- Undefined: the counter is not synthesized and ph_drop_cnt is tied to 0. Drop behaviour is otherwise unchanged.

Test Plan:
- Single photon, no updates: ph_addr=0x12A, ph_tag=0xBEEF at cycle 0 → bram_en_a=1 with bram_addr=0x12A at cycle 1; coef_valid at cycle 4 with coef_tag=0xBEEF and coef_data = preloaded word.
- Update on idle port: upd_valid, upd_addr=0x3FF, upd_data=0x0123456789ABCDEF → upd_ready=1 and bram_we=1 the same cycle. A photon to 0x3FF arriving the next cycle returns 0x0123456789ABCDEF.
- Starvation: photons every cycle with upd_valid held high → reads win for 8 cycles, write forced on the 9th, then reads resume. No drop with FIFO_DEPTH=4, and tags return in order.
- Overflow: photons every cycle with updates continuously pending → FIFO fills and at least one drop occurs; ph_drop_cnt equals the exact number dropped (0 when ENERGY_LUT_DROP_CNT_EN is undefined).
- Reset mid-flight: assert rst_n low one cycle after a read issue → all outputs 0 immediately; no coef_valid after release; FIFO empty; ph_drop_cnt=0.
- Drop-count saturation: force 65540 drops → ph_drop_cnt holds 0xFFFF.
